// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, framebuffer geometry and types for vga_scanout.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int SCALE    = 4;
  localparam int FB_DEPTH = FB_W * FB_H;

  typedef logic [2:0]  colour_t;
  typedef logic [14:0] fb_addr_t;

  localparam colour_t BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    CLR_START,
    CLR_RUN,
    CLR_DONE
  } clr_state_t;

  function automatic fb_addr_t fb_addr(input logic [7:0] x, input logic [6:0] y);
    return fb_addr_t'(y) * fb_addr_t'(FB_W) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// 19200x3 simple dual-port framebuffer RAM: one write port, one synchronous
// read port with read-before-write behaviour on a same-address collision.
module fb_ram
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     wr_en,
  input  fb_addr_t wr_addr,
  input  colour_t  wr_data,
  input  fb_addr_t rd_addr,
  output colour_t  rd_data
);

  // NOTE: the storage array has no reset so it maps onto block RAM; contents
  // are whatever the last write (or power-up) left there.
  colour_t mem [FB_DEPTH];
  colour_t rd_data_q;

  // NOTE: non-blocking assignments here are what give read-before-write: the
  // read samples mem before the same-edge write lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_scanout.sv
// Pixel-write sink, 160x120x3 framebuffer and 640x480@60 scan-out with 4x4 pixel
// replication. Optional power-up clear sweep enabled by VGA_SCANOUT_CLEAR_EN.
module vga_scanout
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  colour_t    wr_c,
  input  logic       wr_en,
  output logic       busy,
  output logic       frame_tick,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b
);

  logic       pix_en_q, pix_en_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d;
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  colour_t    rgb_q, rgb_d;

  logic       h_last, v_last, visible, wr_ok, ram_we;
  fb_addr_t   rd_addr, ram_waddr;
  colour_t    ram_wdata, ram_rdata;

  // NOTE: every always_comb output gets a default at the top so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    h_last   = (h_q == 10'(H_TOTAL - 1));
    v_last   = (v_q == 10'(V_TOTAL - 1));
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en_q) begin
      h_d = h_last ? '0 : h_q + 10'd1;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + 10'd1;
      end
    end

    visible  = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
    hs1_d    = !((h_q >= 10'(H_VISIBLE + H_FP)) && (h_q < 10'(H_VISIBLE + H_FP + H_SYNC)));
    vs1_d    = !((v_q >= 10'(V_VISIBLE + V_FP)) && (v_q < 10'(V_VISIBLE + V_FP + V_SYNC)));
    blank1_d = visible;
    // SCALE = 4: framebuffer coordinates are the screen coordinates shifted by 2.
    rd_addr  = visible ? fb_addr(h_q[9:2], v_q[8:2]) : '0;

    hs_d     = hs1_q;
    vs_d     = vs1_q;
    blank_d  = blank1_q;
    rgb_d    = blank1_q ? ram_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      blank1_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      blank1_q <= blank1_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      rgb_q    <= rgb_d;
    end
  end

  assign frame_tick = pix_en_q && h_last && (v_q == 10'(V_VISIBLE - 1));
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign vga_blank  = blank_q;
  assign vga_r      = rgb_q[2];
  assign vga_g      = rgb_q[1];
  assign vga_b      = rgb_q[0];

`ifdef VGA_SCANOUT_CLEAR_EN
  clr_state_t clr_state_q, clr_state_d;
  fb_addr_t   clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clr_state_q <= CLR_START;
      clr_addr_q  <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_addr_q  <= clr_addr_d;
    end
  end

  always_comb begin
    clr_state_d = clr_state_q;
    clr_addr_d  = clr_addr_q;
    unique case (clr_state_q)
      CLR_START: begin
        clr_state_d = CLR_RUN;
        clr_addr_d  = '0;
      end
      CLR_RUN: begin
        clr_addr_d = clr_addr_q + fb_addr_t'(1);
        if (clr_addr_q == fb_addr_t'(FB_DEPTH - 1)) begin
          clr_state_d = CLR_DONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (clr_state_q == CLR_RUN);
  end
`else
  assign busy = 1'b0;
`endif

  // The clear sweep owns the write port while busy; user writes are dropped.
  always_comb begin
    wr_ok     = wr_en && !busy && (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
    ram_we    = wr_ok;
    ram_waddr = fb_addr(wr_x, wr_y);
    ram_wdata = wr_c;
`ifdef VGA_SCANOUT_CLEAR_EN
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = BG_COLOUR;
    end
`endif
  end

  fb_ram u_fb_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

endmodule
